// File: rtl/basilisk_mult_arbiter_pkg.sv
// Shared types for the basilisk multiplier arbiter: command/result payloads and
// the requester id carried through the in-flight tag FIFO.
package basilisk_mult_arbiter_pkg;

    localparam int BASILISK_MULT_MAX_REQUESTERS = 8;

    typedef logic [$clog2(BASILISK_MULT_MAX_REQUESTERS)-1:0] basilisk_mult_requester_id_t;

    typedef struct packed {
        logic [15:0] operand_a;
        logic [15:0] operand_b;
        logic        enable_macc;
    } basilisk_mult_command_t;

    typedef struct packed {
        logic [31:0] product;
        logic        overflow;
    } basilisk_mult_result_t;

    function automatic basilisk_mult_requester_id_t rr_next(
        input basilisk_mult_requester_id_t cur,
        input int                          num
    );
        return (cur == basilisk_mult_requester_id_t'(num - 1)) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/basilisk_mult_arbiter_tag_fifo.sv
// In-order FIFO of requester ids, one entry per multiplier operation in flight.
// A dedicated count register tells full from empty since the pointers wrap naturally.
module basilisk_mult_tag_fifo
    import basilisk_mult_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  basilisk_mult_requester_id_t  push_id_i,
    input  logic                         pop_i,
    output basilisk_mult_requester_id_t  head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    basilisk_mult_requester_id_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/basilisk_mult_arbiter.sv
// Round-robin sharing of one basilisk multiplier pipeline between several issue
// sources, with credit-limited issue and in-order routing of results back to owners.
module basilisk_mult_arbiter
    import basilisk_mult_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS       = 2,
    parameter int MAX_IN_FLIGHT        = 8,
    parameter int OUTPUT_REGISTER_MODE = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQUESTERS-1:0]                   mult_request_valid_i,
    output logic [NUM_REQUESTERS-1:0]                   mult_request_ready_o,
    input  basilisk_mult_command_t [NUM_REQUESTERS-1:0] mult_request_payload_i,
    output logic                                        mult_command_valid_o,
    input  logic                                        mult_command_ready_i,
    output basilisk_mult_command_t                      mult_command_payload_o,
    input  logic                                        mult_result_valid_i,
    output logic                                        mult_result_ready_o,
    input  basilisk_mult_result_t                       mult_result_payload_i,
    output logic [NUM_REQUESTERS-1:0]                   requester_result_valid_o,
    input  logic [NUM_REQUESTERS-1:0]                   requester_result_ready_i,
    output basilisk_mult_result_t [NUM_REQUESTERS-1:0]  requester_result_payload_o,
    output logic [$clog2(MAX_IN_FLIGHT+1)-1:0]          in_flight_count_o,
    output logic                                        orphan_result_o,
    output basilisk_mult_requester_id_t                 rr_ptr_o
);
    basilisk_mult_requester_id_t rr_ptr_q, rr_ptr_d, grant_idx, hi_idx, wrap_idx, head_tag;
    basilisk_mult_command_t      grant_payload;
    logic grant_valid, hi_hit, wrap_hit;
    logic stage_ready, issue_ok, issue_fire;
    logic fifo_full, fifo_empty, head_ready, pop;
    logic orphan_q, orphan_d;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_hit   = 1'b0;
        wrap_hit = 1'b0;
        hi_idx   = '0;
        wrap_idx = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (mult_request_valid_i[i]) begin
                wrap_hit = 1'b1;
                wrap_idx = basilisk_mult_requester_id_t'(i);
                if (basilisk_mult_requester_id_t'(i) >= rr_ptr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = basilisk_mult_requester_id_t'(i);
                end
            end
        end
        grant_valid = hi_hit || wrap_hit;
        grant_idx   = hi_hit ? hi_idx : wrap_idx;
    end

    always_comb begin
        grant_payload = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_idx == basilisk_mult_requester_id_t'(i)) grant_payload = mult_request_payload_i[i];
        end
    end

    assign issue_ok   = !fifo_full && !rst;
    assign issue_fire = grant_valid && stage_ready && issue_ok;

    always_comb begin
        mult_request_ready_o = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            mult_request_ready_o[i] = issue_fire && (grant_idx == basilisk_mult_requester_id_t'(i));
        end
    end

    generate
        if (OUTPUT_REGISTER_MODE != 0) begin : g_out_reg
            logic                   cmd_valid_q;
            basilisk_mult_command_t cmd_payload_q;

            assign stage_ready            = !cmd_valid_q || mult_command_ready_i;
            assign mult_command_valid_o   = cmd_valid_q && !rst;
            assign mult_command_payload_o = cmd_payload_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cmd_valid_q <= 1'b0;
                end else if (stage_ready) begin
                    cmd_valid_q <= issue_fire;
                end
            end

            always_ff @(posedge clk) begin
                if (issue_fire) cmd_payload_q <= grant_payload;
            end
        end else begin : g_out_pass
            assign stage_ready            = mult_command_ready_i;
            assign mult_command_valid_o   = grant_valid && issue_ok;
            assign mult_command_payload_o = grant_payload;
        end
    endgenerate

    basilisk_mult_tag_fifo #(
        .DEPTH(MAX_IN_FLIGHT)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (issue_fire),
        .push_id_i(grant_idx),
        .pop_i    (pop),
        .head_o   (head_tag),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (in_flight_count_o)
    );

    // With no owner recorded, results are drained and flagged rather than wedging the pipeline.
    always_comb begin
        head_ready               = 1'b0;
        requester_result_valid_o = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (head_tag == basilisk_mult_requester_id_t'(i)) head_ready = requester_result_ready_i[i];
            requester_result_valid_o[i] = !rst && !fifo_empty && mult_result_valid_i
                                          && (head_tag == basilisk_mult_requester_id_t'(i));
        end
        mult_result_ready_o = !rst && (fifo_empty || head_ready);
        pop                 = mult_result_valid_i && mult_result_ready_o && !fifo_empty;
        orphan_d            = orphan_q || (mult_result_valid_i && fifo_empty);
        rr_ptr_d            = issue_fire ? rr_next(grant_idx, NUM_REQUESTERS) : rr_ptr_q;
    end

    assign requester_result_payload_o = {NUM_REQUESTERS{mult_result_payload_i}};
    assign orphan_result_o            = orphan_q;
    assign rr_ptr_o                   = rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: tb/tb_basilisk_mult_arbiter.sv
// Bench for basilisk_mult_arbiter: directed scenarios plus randomized traffic, all
// checked against a queue-based model of issue order, ownership and result routing.
module tb_basilisk_mult_arbiter;
    import basilisk_mult_arbiter_pkg::*;

    localparam int NR   = 2;
    localparam int MAXF = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0] req_valid, req_ready;
    basilisk_mult_command_t [NR-1:0] req_pay;
    logic cmd_valid, cmd_ready;
    basilisk_mult_command_t cmd_pay;
    logic res_valid, res_ready;
    basilisk_mult_result_t res_pay;
    logic [NR-1:0] rr_valid, rr_ready_in;
    basilisk_mult_result_t [NR-1:0] rr_pay;
    logic [3:0] count;
    logic orphan;
    basilisk_mult_requester_id_t rr_ptr;

    basilisk_mult_arbiter #(
        .NUM_REQUESTERS(NR),
        .MAX_IN_FLIGHT(MAXF),
        .OUTPUT_REGISTER_MODE(1)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .mult_request_valid_i      (req_valid),
        .mult_request_ready_o      (req_ready),
        .mult_request_payload_i    (req_pay),
        .mult_command_valid_o      (cmd_valid),
        .mult_command_ready_i      (cmd_ready),
        .mult_command_payload_o    (cmd_pay),
        .mult_result_valid_i       (res_valid),
        .mult_result_ready_o       (res_ready),
        .mult_result_payload_i     (res_pay),
        .requester_result_valid_o  (rr_valid),
        .requester_result_ready_i  (rr_ready_in),
        .requester_result_payload_o(rr_pay),
        .in_flight_count_o         (count),
        .orphan_result_o           (orphan),
        .rr_ptr_o                  (rr_ptr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int                     tag_q[$];
    basilisk_mult_command_t cmd_q[$];
    int                     rr_m     = 0;
    bit                     orphan_m = 1'b0;
    logic [NR-1:0]          req_acc  = '0;
    bit                     res_acc  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic basilisk_mult_command_t rand_cmd();
        basilisk_mult_command_t c;
        c.operand_a   = 16'($urandom);
        c.operand_b   = 16'($urandom);
        c.enable_macc = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic basilisk_mult_result_t rand_res();
        basilisk_mult_result_t r;
        r.product  = $urandom;
        r.overflow = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic int model_grant(input logic [NR-1:0] v, input int rr);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (rr + k) % NR;
            if (((v >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    // Evaluated mid-cycle: compares DUT against the model, then applies this cycle's transfers.
    task automatic eval();
        int g;
        logic [NR-1:0] exp_rdy, exp_rv;
        logic exp_rr;
        bit stage_rdy;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_cmd_valid", cmd_valid, 0);
            chk("rst_res_valid", rr_valid, 0);
            chk("rst_res_ready", res_ready, 0);
            tag_q.delete();
            cmd_q.delete();
            rr_m     = 0;
            orphan_m = 1'b0;
            req_acc  = '0;
            res_acc  = 1'b0;
        end else begin
            g         = model_grant(req_valid, rr_m);
            stage_rdy = (cmd_q.size() == 0) || cmd_ready;
            exp_rdy   = '0;
            if (g >= 0 && stage_rdy && tag_q.size() < MAXF) exp_rdy = NR'(1 << g);
            chk("req_ready", req_ready, exp_rdy);
            chk("cmd_valid", cmd_valid, cmd_q.size() != 0);
            if (cmd_q.size() != 0) chk("cmd_payload", cmd_pay, cmd_q[0]);
            chk("in_flight_count", count, tag_q.size());
            chk("rr_ptr", rr_ptr, rr_m);
            chk("orphan", orphan, orphan_m);
            exp_rv = '0;
            exp_rr = 1'b1;
            if (tag_q.size() != 0) begin
                exp_rr = ((rr_ready_in >> tag_q[0]) & 1) != 0;
                if (res_valid) begin
                    exp_rv = NR'(1 << tag_q[0]);
                    chk("route_payload", (tag_q[0] == 0) ? rr_pay[0] : rr_pay[1], res_pay);
                end
            end
            chk("res_valid_vec", rr_valid, exp_rv);
            chk("res_ready", res_ready, exp_rr);

            if (cmd_q.size() != 0 && cmd_ready) void'(cmd_q.pop_front());
            req_acc = exp_rdy & req_valid;
            if (exp_rdy != 0) begin
                tag_q.push_back(g);
                cmd_q.push_back((g == 0) ? req_pay[0] : req_pay[1]);
                rr_m = (g + 1) % NR;
            end
            res_acc = res_valid && exp_rr;
            if (res_acc) begin
                if (tag_q.size() != 0) void'(tag_q.pop_front());
                else orphan_m = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        eval();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        step();
        adv();
    endtask

    task automatic drain();
        req_valid   = '0;
        cmd_ready   = 1'b1;
        rr_ready_in = '1;
        for (int c = 0; c < 40 && (tag_q.size() != 0 || cmd_q.size() != 0); c++) begin
            res_valid = (tag_q.size() != 0);
            res_pay   = rand_res();
            cyc();
        end
        res_valid = 1'b0;
        chk("drain_empty", count, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int s3_tags[4];
        basilisk_mult_command_t pay_a, pay_b;
        s3_tags = '{1, 0, 0, 1};
        pay_a   = '{operand_a: 16'h1111, operand_b: 16'h2222, enable_macc: 1'b0};
        pay_b   = '{operand_a: 16'h3333, operand_b: 16'h4444, enable_macc: 1'b1};

        rst         = 1'b1;
        req_valid   = '0;
        req_pay     = '0;
        cmd_ready   = 1'b0;
        res_valid   = 1'b0;
        res_pay     = '0;
        rr_ready_in = '0;
        adv();
        cyc();
        cyc();
        rst = 1'b0;

        // 1: alternating issue with both requesters always valid
        req_valid = 2'b11;
        req_pay   = {pay_b, pay_a};
        cmd_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("s1_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            adv();
        end
        req_valid = '0;
        step();
        chk("s1_last_payload", cmd_pay, pay_b);
        adv();
        drain();

        // 2: credit limit
        req_valid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            req_pay = {rand_cmd(), rand_cmd()};
            cyc();
        end
        step();
        chk("s2_full_count", count, MAXF);
        chk("s2_full_stall", req_ready, 0);
        adv();
        res_valid   = 1'b1;
        rr_ready_in = 2'b11;
        res_pay     = rand_res();
        step();
        chk("s2_full_pop_no_issue", req_ready, 0);
        adv();
        res_valid = 1'b0;
        step();
        chk("s2_refill", req_ready != 0, 1);
        adv();
        step();
        chk("s2_full_again", count, MAXF);
        adv();
        drain();

        // 3: tag order 1,0,0,1 routed back in order, with a stalled owner
        for (int c = 0; c < 4; c++) begin
            req_valid = (s3_tags[c] == 1) ? 2'b10 : 2'b01;
            req_pay   = {rand_cmd(), rand_cmd()};
            step();
            chk("s3_issue", req_ready, req_valid);
            adv();
        end
        req_valid   = '0;
        res_valid   = 1'b1;
        rr_ready_in = 2'b01;
        res_pay     = rand_res();
        step();
        chk("s3_stall_ready", res_ready, 0);
        chk("s3_stall_valid", rr_valid, 2'b10);
        adv();
        rr_ready_in = 2'b11;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("s3_route", rr_valid, (s3_tags[c] == 1) ? 2'b10 : 2'b01);
            adv();
            res_pay = rand_res();
        end
        res_valid = 1'b0;
        chk("s3_empty", count, 0);

        // 4: steady push+pop at occupancy 3
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) cyc();
        res_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_pay = {rand_cmd(), rand_cmd()};
            res_pay = rand_res();
            step();
            chk("s4_count", count, 3);
            adv();
        end
        res_valid = 1'b0;
        drain();

        // Randomized traffic with stream-protocol holding on both sides
        req_valid = '0;
        res_valid = 1'b0;
        req_acc   = '0;
        res_acc   = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r[0]] || req_acc[r[0]]) begin
                    req_valid[r[0]] = 1'($urandom_range(0, 1));
                    req_pay[r[0]]   = rand_cmd();
                end
            end
            cmd_ready   = ($urandom_range(0, 3) != 0);
            rr_ready_in = 2'($urandom_range(0, 3));
            if (!res_valid || res_acc) begin
                res_valid = (tag_q.size() != 0) && ($urandom_range(0, 1) != 0);
                res_pay   = rand_res();
            end
            cyc();
        end
        res_valid = 1'b0;
        drain();

        // 5: orphan result with an empty FIFO
        req_valid = '0;
        res_valid = 1'b1;
        res_pay   = rand_res();
        step();
        chk("s5_drain_ready", res_ready, 1);
        chk("s5_no_valid", rr_valid, 0);
        adv();
        res_valid = 1'b0;
        step();
        chk("s5_orphan_set", orphan, 1);
        adv();
        for (int c = 0; c < 3; c++) cyc();
        step();
        chk("s5_orphan_sticky", orphan, 1);
        adv();

        // 6: reset mid-operation with the output stalled
        req_valid = 2'b11;
        cmd_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_pay = {rand_cmd(), rand_cmd()};
            cyc();
        end
        cmd_ready = 1'b0;
        cyc();
        cyc();
        step();
        chk("s6_count_before", count, 5);
        adv();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        step();
        chk("s6_count", count, 0);
        chk("s6_rr_ptr", rr_ptr, 0);
        chk("s6_orphan", orphan, 0);
        chk("s6_cmd_valid", cmd_valid, 0);
        chk("s6_res_valid", rr_valid, 0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
